// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - SPI master: all four modes, configurable width, divider and chip selects
// Optional internal MOSI-to-sample-path loopback under SPI_MASTER_LOOPBACK_EN.
module spi_master_cfg #(
    parameter int  DATA_W   = 8,
    parameter int  NUM_CS   = 4,
    parameter int  CLK_DIV  = 2,
    parameter int  CS_SETUP = 1,
    parameter int  CS_HOLD  = 1,
    localparam int CSW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CSW-1:0]    cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic [NUM_CS-1:0] cs_n
);

    localparam int CNT_MAX0 = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
    localparam int CNT_MAX  = (CNT_MAX0 > CS_HOLD) ? CNT_MAX0 : CS_HOLD;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int EDGE_W   = $clog2(2 * DATA_W + 1);

    localparam logic [CNT_W-1:0]  SETUP_END = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0]  HALF_END  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  HOLD_END  = CNT_W'(CS_HOLD - 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic                sclk_q, sclk_d;
    logic                cpha_q, cpha_d;
    logic                lb_q, lb_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic [NUM_CS-1:0]   cs_dec;
    logic                leading;
    logic                sample_src;
    logic                lb_in;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign lb_in = loopback;
`else
    assign lb_in = 1'b0;
`endif

    // An out-of-range select decodes to no active line, so the frame runs with all cs_n high.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CSW'(i)) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        sclk_d     = sclk_q;
        cpha_d     = cpha_q;
        lb_d       = lb_q;
        cs_n_d     = cs_n_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        leading    = ~edge_q[0];
        sample_src = lb_q ? tx_sh_q[DATA_W-1] : miso;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    edge_d  = '0;
                    sclk_d  = cpol;
                    cpha_d  = cpha;
                    lb_d    = lb_in;
                    tx_sh_d = tx_data;
                    cs_n_d  = cs_dec;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_END) begin
                    state_d = XFER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            XFER: begin
                if (cnt_q == HALF_END) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EDGE_W'(1);
                    if (leading ^ cpha_q) begin
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], sample_src};
                    end
                    // CPHA=1 keeps the MSB through the first leading edge; CPHA=0 skips the final trailing shift.
                    if (cpha_q ? (leading && edge_q != '0) : (!leading && edge_q != LAST_EDGE)) begin
                        tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                    end
                    if (edge_q == LAST_EDGE) begin
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_END) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    cs_n_d     = '1;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            sclk_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lb_q       <= 1'b0;
            cs_n_q     <= '1;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            sclk_q     <= sclk_d;
            cpha_q     <= cpha_d;
            lb_q       <= lb_d;
            cs_n_q     <= cs_n_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign ready    = (state_q == IDLE);
    assign busy     = ~ready;
    assign sclk     = sclk_q;
    assign mosi     = tx_sh_q[DATA_W-1];
    assign cs_n     = cs_n_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb/tb_spi_master_cfg.sv - scoreboard bench for spi_master_cfg with a behavioural SPI slave
module tb_spi_master_cfg;
    localparam int DW      = 8;
    localparam int NCS     = 3;
    localparam int CSW     = 2;
    localparam int L       = 34;
    localparam int FIRST_E = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           cpol = 1'b0;
    logic           cpha = 1'b0;
    logic           miso = 1'b0;
    logic [CSW-1:0] cs_sel = '0;
    logic [DW-1:0]  tx_data = '0;
    logic           ready, busy, rx_valid, sclk, mosi;
    logic [DW-1:0]  rx_data;
    logic [NCS-1:0] cs_n;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic           loopback = 1'b0;
`endif

    spi_master_cfg #(.DATA_W(DW), .NUM_CS(NCS), .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .cpol(cpol), .cpha(cpha),
        .cs_sel(cs_sel), .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(loopback),
`endif
        .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0]  tx;
        logic [DW-1:0]  rxe;
        logic           cpol;
        logic [NCS-1:0] cse;
        int             acc;
    } frame_t;

    frame_t exp_q[$];
    frame_t mfr;
    int vectors = 0;
    int miscompares = 0;
    int last_rx_cyc = 0;
    logic cs_bad = 1'b0;

    int            s_n = 0;
    int            s_first = 0;
    logic [DW-1:0] s_word = '0;
    logic [DW-1:0] s_cap = '0;
    logic          s_cpha = 1'b0;
    logic          sclk_prev = 1'b0;
    logic          busy_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Slave: bit presented after SCLK edge n; CPHA=0 advances on trailing edges, CPHA=1 on leading edges after the first.
    function automatic int slave_bit(input int n, input logic pha);
        int b;
        b = pha ? (DW - 1 - (n - 1) / 2) : (DW - 1 - n / 2);
        return (b < 0) ? 0 : b;
    endfunction

    always @(posedge clk) begin
        #1;
        if (busy_prev && sclk !== sclk_prev) begin
            s_n++;
            if (s_n == 1) s_first = cyc;
            if (((s_n % 2) == 1) != s_cpha) s_cap = {s_cap[DW-2:0], mosi};
            miso = s_word[slave_bit(s_n, s_cpha)];
        end
        sclk_prev = sclk;
        busy_prev = busy;
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (rx_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rx_valid", rx_valid, 0);
                end else begin
                    mfr = exp_q.pop_front();
                    chk("rx_data", rx_data, mfr.rxe);
                    chk("latency", cyc - mfr.acc, L);
                    chk("mosi_word", s_cap, mfr.tx);
                    chk("sclk_edges", s_n, 2 * DW);
                    chk("first_sclk", s_first - mfr.acc, FIRST_E);
                    chk("sclk_idle", sclk, mfr.cpol);
                    chk("cs_n_release", cs_n, 3'b111);
                    chk("ready_at_done", ready, 1);
                    chk("cs_n_during", cs_bad, 0);
                    cs_bad = 1'b0;
                    last_rx_cyc = cyc;
                end
            end else if (busy && exp_q.size() > 0 && cs_n !== exp_q[0].cse) begin
                cs_bad = 1'b1;
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].acc + L + 4) begin
                chk("frame_timeout", cyc - exp_q[0].acc, L);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [DW-1:0] tx, input logic [DW-1:0] sw, input logic pol,
                        input logic pha, input logic [CSW-1:0] sel, input logic lb, output int acc_o);
        frame_t fr;
        int w;
        w = 0;
        @(negedge clk);
        while (!ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", ready, 1);
        start   = 1'b1;
        tx_data = tx;
        cpol    = pol;
        cpha    = pha;
        cs_sel  = sel;
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback = lb;
`endif
        fr.tx   = tx;
        fr.rxe  = lb ? tx : sw;
        fr.cpol = pol;
        fr.cse  = (int'(sel) < NCS) ? ~(3'b001 << sel) : 3'b111;
        fr.acc  = cyc + 1;
        acc_o   = fr.acc;
        exp_q.push_back(fr);
        @(posedge clk);
        #2;
        s_n    = 0;
        s_cap  = '0;
        s_cpha = pha;
        s_word = lb ? '0 : sw;
        miso   = lb ? 1'b0 : sw[DW-1];
        chk("mosi_msb", mosi, tx[DW-1]);
        chk("cs_n_setup", cs_n, fr.cse);
        chk("busy_after_accept", busy, 1);
        tx_data = DW'($urandom);
        cpol    = 1'($urandom);
        cpha    = 1'($urandom);
        cs_sel  = CSW'($urandom);
    endtask

    task automatic stop();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || !ready) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_rx_data"}, rx_data, 0);
        chk({tag, "_sclk"}, sclk, 0);
        chk({tag, "_mosi"}, mosi, 0);
        chk({tag, "_cs_n"}, cs_n, 3'b111);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int a, a2;
        logic lb;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        send(8'hB1, 8'h5A, 1'b0, 1'b0, 2'd2, 1'b0, a);
        stop();
        wait_idle();

        send(8'h3C, 8'hC3, 1'b1, 1'b1, 2'd0, 1'b0, a);
        stop();
        wait_idle();
        chk("mode3_idle_high", sclk, 1);

        send(8'h01, 8'h96, 1'b0, 1'b0, 2'd1, 1'b0, a);
        send(8'h80, 8'h69, 1'b0, 1'b0, 2'd1, 1'b0, a2);
        stop();
        chk("b2b_accept_in_rx_valid_cycle", a2 - last_rx_cyc, 1);
        wait_idle();

        send(8'hE7, 8'h18, 1'b1, 1'b0, 2'd1, 1'b0, a);
        stop();
        while (cyc < a + 9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check_reset_vals("midreset");
        void'(exp_q.pop_front());
        cs_bad = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        send(8'h4D, 8'hB2, 1'b0, 1'b1, 2'd0, 1'b0, a);
        stop();
        wait_idle();

        send(8'h5F, 8'hA0, 1'b0, 1'b0, 2'd3, 1'b0, a);
        stop();
        wait_idle();

`ifdef SPI_MASTER_LOOPBACK_EN
        send(8'hA5, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1, a);
        stop();
        wait_idle();
`endif

        for (int i = 0; i < 12; i++) begin
`ifdef SPI_MASTER_LOOPBACK_EN
            lb = 1'($urandom);
`else
            lb = 1'b0;
`endif
            send(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom),
                 CSW'($urandom_range(0, 3)), lb, a);
            if ($urandom_range(0, 1) == 1) stop();
        end
        stop();
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
